imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the RISC-V decode path. Each accepted 32-bit instruction word produces a sign- or zero-extended immediate of width XLEN, a format code and a sideband tag. Results are held behind a valid/ready handshake with an optional two-entry skid buffer, so the stage can stall and flush cleanly in a pipelined core. Relative to the combinational immediate decoder, it adds AUIPC, CSR zimm, RV64 sign-extension, a format output, backpressure and flush.

---
 rtl/imm_gen_stage.sv | 148 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate-generation stage: decodes the immediate at capture and
// presents it behind a valid/ready handshake, optionally through a two-entry skid buffer.
module imm_gen_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  Imm_out,
  output logic [2:0]       fmt_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned EntW = XLEN + 3 + TAG_W;

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [EntW-1:0]   out_q, out_d;
  logic [EntW-1:0]   skid_q, skid_d;
  logic [EntW-1:0]   dec_entry;
  logic [31:0]       imm32;
  logic [2:0]        dec_fmt;
  logic [XLEN-1:0]   imm_ext;
  logic              in_fire, out_fire;

  // Every format fits a sign-extended 32-bit value (zimm has bit 31 clear), so one
  // 32-bit result is built and then widened to XLEN.
  always_comb begin
    imm32   = '0;
    dec_fmt = FmtNone;
    case (inst_code[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        imm32   = {{20{inst_code[31]}}, inst_code[31:20]};
        dec_fmt = FmtI;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          imm32   = {{20{inst_code[31]}}, inst_code[31:20]};
          dec_fmt = FmtI;
        end
      end
      7'b0100011: begin
        imm32   = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
        dec_fmt = FmtS;
      end
      7'b1100011: begin
        imm32   = {{20{inst_code[31]}}, inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
        dec_fmt = FmtB;
      end
      7'b0110111, 7'b0010111: begin
        imm32   = {inst_code[31:12], 12'b0};
        dec_fmt = FmtU;
      end
      7'b1101111: begin
        imm32   = {{12{inst_code[31]}}, inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};
        dec_fmt = FmtJ;
      end
      7'b1110011: begin
        if (inst_code[14]) begin
          imm32   = {27'b0, inst_code[19:15]};
          dec_fmt = FmtZ;
        end
      end
      default: ;
    endcase
    imm_ext       = {XLEN{imm32[31]}};
    imm_ext[31:0] = imm32;
  end

  assign dec_entry = {imm_ext, dec_fmt, in_tag};

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (SKID != 0) ? ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign {Imm_out, fmt_out, out_tag} = out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            out_d   = dec_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            out_d = dec_entry;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: without it in_ready implies out_ready.
            skid_d  = dec_entry;
            state_d = StTwo;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit skid-buffered instance and a 64-bit
// single-register instance driven from one decode table plus handshake sequences.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: XLEN=32, SKID=1
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_inst, a_imm;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [2:0]  a_fmt;

  // Instance b: XLEN=64, SKID=0
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_inst;
  logic [63:0] b_imm;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [2:0]  b_fmt;

  imm_gen_stage #(.XLEN(32), .SKID(1), .TAG_W(5)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .inst_code (a_inst),
    .in_tag    (a_in_tag),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .Imm_out   (a_imm),
    .fmt_out   (a_fmt),
    .out_tag   (a_out_tag)
  );

  imm_gen_stage #(.XLEN(64), .SKID(0), .TAG_W(5)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .inst_code (b_inst),
    .in_tag    (b_in_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .Imm_out   (b_imm),
    .fmt_out   (b_fmt),
    .out_tag   (b_out_tag)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs[NVec];

  initial begin
    // addi, jal, beq(-4), sw(-4), auipc, lui, csrrwi, ecall, addiw, lw, jalr, add, beq(+8)
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    vecs[1]  = '{32'h0080006F, 32'h00000008, 3'd5, 64'h0000000000000008, 3'd5};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    vecs[3]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
    vecs[4]  = '{32'h12345017, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4};
    vecs[5]  = '{32'h80000037, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    vecs[6]  = '{32'h300FD073, 32'h0000001F, 3'd6, 64'h000000000000001F, 3'd6};
    vecs[7]  = '{32'h00000073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
    vecs[8]  = '{32'h0010009B, 32'h00000000, 3'd0, 64'h0000000000000001, 3'd1};
    vecs[9]  = '{32'h00412083, 32'h00000004, 3'd1, 64'h0000000000000004, 3'd1};
    vecs[10] = '{32'h7FF080E7, 32'h000007FF, 3'd1, 64'h00000000000007FF, 3'd1};
    vecs[11] = '{32'h002081B3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
    vecs[12] = '{32'h00208463, 32'h00000008, 3'd3, 64'h0000000000000008, 3'd3};

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_inst = '0; a_in_tag = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_inst = '0; b_in_tag = '0;
    #12;
    check("reset a_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("reset a_imm", {32'd0, a_imm}, 64'd0);
    check("reset a_fmt", {61'd0, a_fmt}, 64'd0);
    check("reset a_tag", {59'd0, a_out_tag}, 64'd0);
    check("reset b_out_valid", {63'd0, b_out_valid}, 64'd0);
    check("reset b_imm", b_imm, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset a_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("post-reset b_in_ready", {63'd0, b_in_ready}, 64'd1);

    // Decode table, streamed back-to-back with out_ready high on both instances.
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      a_in_valid = 1; a_inst = vecs[i].inst; a_in_tag = 5'(i + 1);
      b_in_valid = 1; b_inst = vecs[i].inst; b_in_tag = 5'(i + 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d a_valid", i), {63'd0, a_out_valid}, 64'd1);
      check($sformatf("vec%0d a_imm", i), {32'd0, a_imm}, {32'd0, vecs[i].imm32});
      check($sformatf("vec%0d a_fmt", i), {61'd0, a_fmt}, {61'd0, vecs[i].fmt32});
      check($sformatf("vec%0d a_tag", i), {59'd0, a_out_tag}, 64'(i + 1));
      check($sformatf("vec%0d b_imm", i), b_imm, vecs[i].imm64);
      check($sformatf("vec%0d b_fmt", i), {61'd0, b_fmt}, {61'd0, vecs[i].fmt64});
      check($sformatf("vec%0d b_tag", i), {59'd0, b_out_tag}, 64'(i + 1));
    end
    @(negedge clk); a_in_valid = 0; b_in_valid = 0;
    @(posedge clk); #1;
    check("drain a_valid", {63'd0, a_out_valid}, 64'd0);
    check("drain b_valid", {63'd0, b_out_valid}, 64'd0);

    // Skid backpressure on instance a: tags 1,2 accepted, 3 held off, then 1,2,3 out.
    @(negedge clk); a_out_ready = 0; a_in_valid = 1; a_inst = 32'hFFF00093; a_in_tag = 5'd1;
    @(posedge clk); #1;
    check("bp a_tag after 1", {59'd0, a_out_tag}, 64'd1);
    check("bp a_in_ready after 1", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk); a_in_tag = 5'd2;
    @(posedge clk); #1;
    check("bp a_in_ready after 2", {63'd0, a_in_ready}, 64'd0);
    check("bp a_tag held 1", {59'd0, a_out_tag}, 64'd1);
    @(negedge clk); a_in_tag = 5'd3;
    @(posedge clk); #1;
    check("bp a_in_ready stall", {63'd0, a_in_ready}, 64'd0);
    check("bp a_tag still 1", {59'd0, a_out_tag}, 64'd1);
    check("bp a_imm stable", {32'd0, a_imm}, 64'hFFFFFFFF);
    @(negedge clk); a_out_ready = 1;
    @(posedge clk); #1;
    check("bp a_out tag 2", {59'd0, a_out_tag}, 64'd2);
    check("bp a_in_ready reopen", {63'd0, a_in_ready}, 64'd1);
    @(posedge clk); #1;
    check("bp a_out tag 3", {59'd0, a_out_tag}, 64'd3);
    check("bp a_valid tag 3", {63'd0, a_out_valid}, 64'd1);
    @(negedge clk); a_in_valid = 0;
    @(posedge clk); #1;
    check("bp a_empty", {63'd0, a_out_valid}, 64'd0);

    // Single-register backpressure on instance b: in_ready follows out_ready combinationally.
    @(negedge clk); b_out_ready = 0; b_in_valid = 1; b_inst = 32'h00412083; b_in_tag = 5'd1;
    @(posedge clk); #1;
    check("b bp in_ready low", {63'd0, b_in_ready}, 64'd0);
    @(negedge clk); b_in_tag = 5'd2;
    @(posedge clk); #1;
    check("b bp tag held", {59'd0, b_out_tag}, 64'd1);
    @(negedge clk); b_out_ready = 1; #1;
    check("b bp in_ready comb", {63'd0, b_in_ready}, 64'd1);
    @(posedge clk); #1;
    check("b bp tag 2", {59'd0, b_out_tag}, 64'd2);
    @(negedge clk); b_in_valid = 0;
    @(posedge clk); #1;

    // Flush while holding two entries with a new input presented.
    @(negedge clk); a_out_ready = 0; a_in_valid = 1; a_in_tag = 5'd5;
    @(posedge clk);
    @(negedge clk); a_in_tag = 5'd6;
    @(posedge clk); #1;
    check("flush setup in_ready", {63'd0, a_in_ready}, 64'd0);
    @(negedge clk); a_flush = 1; a_in_tag = 5'd7;
    @(posedge clk); #1;
    check("flush a_valid", {63'd0, a_out_valid}, 64'd0);
    check("flush a_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk); a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("flush no ghost %0d", k), {63'd0, a_out_valid}, 64'd0);
    end

    // Asynchronous reset between clock edges.
    @(negedge clk); a_in_valid = 1; a_in_tag = 5'd9; b_in_valid = 1; b_in_tag = 5'd9;
    b_inst = 32'h80000037;
    @(posedge clk); #1;
    check("pre-reset a_valid", {63'd0, a_out_valid}, 64'd1);
    check("pre-reset b_imm", b_imm, 64'hFFFFFFFF80000000);
    a_in_valid = 0; b_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst a_valid", {63'd0, a_out_valid}, 64'd0);
    check("async rst a_imm", {32'd0, a_imm}, 64'd0);
    check("async rst a_tag", {59'd0, a_out_tag}, 64'd0);
    check("async rst b_valid", {63'd0, b_out_valid}, 64'd0);
    check("async rst b_imm", b_imm, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("release a_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("release b_in_ready", {63'd0, b_in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
